// File: rtl/syndcnt_pkg.sv
// Shared types and limits for the syndcnt_n counter family.
package syndcnt_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_MOD     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } cnt_mode_t;

endpackage

// File: rtl/syndcnt_next.sv
// Combinational next-state logic for syndcnt_n: clear/load/count priority,
// terminal detection and one-shot completion.
module syndcnt_next
    import syndcnt_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    input  logic [W-1:0] term,
    input  logic         up,
    input  cnt_mode_t    mode,
    input  logic         done,
    input  logic         ci,
    input  logic         ld,
    input  logic         cll,
    output logic [W-1:0] q_nxt_c,
    output logic         done_nxt_c,
    output logic         at_end_c
);

    logic [W-1:0] q_step;

    // Terminal value: fixed rails in free-run, TERM in modulo/one-shot.
    always_comb begin
        at_end_c = 1'b0;
        if (mode == MODE_MOD || mode == MODE_ONESHOT) begin
            at_end_c = (q == term);
        end else if (up) begin
            at_end_c = (q == {W{1'b1}});
        end else begin
            at_end_c = (q == {W{1'b0}});
        end
    end

    always_comb begin
        q_step     = up ? (q + W'(1)) : (q - W'(1));
        q_nxt_c    = q;
        done_nxt_c = done & (mode == MODE_ONESHOT);

        if (!cll) begin
            q_nxt_c    = '0;
            done_nxt_c = 1'b0;
        end else if (ld) begin
            q_nxt_c    = d;
            done_nxt_c = 1'b0;
        end else if (ci) begin
            unique case (mode)
                MODE_MOD: begin
                    q_nxt_c = at_end_c ? d : q_step;
                end
                MODE_ONESHOT: begin
                    // Completed one-shot holds its value until cleared or reloaded.
                    if (!done) begin
                        if (at_end_c) begin
                            done_nxt_c = 1'b1;
                        end else begin
                            q_nxt_c = q_step;
                        end
                    end
                end
                default: begin
                    q_nxt_c = q_step;
                end
            endcase
        end
    end

endmodule

// File: rtl/syndcnt_n.sv
// Parametrised cascadable up/down counter with load, modulo and one-shot modes.
module syndcnt_n
    import syndcnt_pkg::*;
#(
    parameter int unsigned   W         = 8,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         CLK,
    input  logic         RESL,
    input  logic         CLL,
    input  logic         LD,
    input  logic [W-1:0] D,
    input  logic         CI,
    input  logic         UP,
    input  logic [1:0]   MODE,
    input  logic [W-1:0] TERM,
    output logic [W-1:0] Q,
    output logic [W-1:0] QB,
    output logic         CO,
    output logic         DONE
);

    if (W < 2 || W > MAX_W) begin : g_w_range
        $error("syndcnt_n: W must be within 2..32");
    end

    cnt_mode_t    mode_e;
    logic [W-1:0] q_r;
    logic [W-1:0] q_nxt_c;
    logic         done_r;
    logic         done_nxt_c;
    logic         at_end_c;

    assign mode_e = cnt_mode_t'(MODE);

    syndcnt_next #(.W(W)) u_next (
        .q          (q_r),
        .d          (D),
        .term       (TERM),
        .up         (UP),
        .mode       (mode_e),
        .done       (done_r),
        .ci         (CI),
        .ld         (LD),
        .cll        (CLL),
        .q_nxt_c    (q_nxt_c),
        .done_nxt_c (done_nxt_c),
        .at_end_c   (at_end_c)
    );

    always_ff @(posedge CLK or negedge RESL) begin
        if (!RESL) begin
            q_r    <= RESET_VAL;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_c;
            done_r <= done_nxt_c;
        end
    end

    // Carry-out stays combinational so chained stages ripple within one cycle.
    assign CO   = CI & at_end_c & ~((mode_e == MODE_ONESHOT) & done_r);
    assign Q    = q_r;
    assign QB   = ~q_r;
    assign DONE = done_r;

endmodule

// File: doc/syndcnt_n.md
Name: syndcnt_n

Overview:
- Parametrised N-bit synchronous counter; successor to the 1-bit cascadable SYNDCNTC cell.
- Keeps the CI/CO cascade and the active-low synchronous clear (CLL).
- Adds:
  - parallel load
  - up/down direction
  - modulo reload and one-shot modes
  - asynchronous reset
- Used for video/timer position counters, either stand-alone or chained through CI/CO.

Parameters:
- W, 8, counter width in bits (legal range 2..32).
- RESET_VAL, 0, value of Q after RESL is asserted (W bits).

Ports:
- CLK  in  1  counter clock; all state changes on its rising edge.
- RESL  in  1  asynchronous active-low reset.
- CLL  in  1  synchronous clear, active-low.
- LD  in  1  synchronous parallel load, active-high.
- D  in  W  load value; also the reload value in modulo mode.
- CI  in  1  count enable / carry-in.
- UP  in  1  1 = increment, 0 = decrement.
- MODE  in  2  00 free-run, 01 modulo, 10 one-shot, 11 behaves as 00.
- TERM  in  W  terminal value, used in modes 01 and 10.
- Q  out  W  count value.
- QB  out  W  bitwise complement of Q.
- CO  out  1  combinational carry-out, for cascading.
- DONE  out  1  registered sticky one-shot completion flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESL. While RESL = 0: Q = RESET_VAL, QB = ~RESET_VAL, DONE = 0.
- Release of RESL takes effect at the first rising edge of CLK after release.
- Priority at each rising edge: CLL = 0 > LD = 1 > count > hold.
- CLL = 0: Q <= 0, DONE <= 0.
  - This overrides LD and CI, as the 1-bit cell's clear overrides its count.
- LD = 1 (with CLL = 1): Q <= D, DONE <= 0.
- Count occurs only when CI = 1, CLL = 1 and LD = 0. Define at_end:
  - MODE 00/11: at_end = (Q == all ones) when UP = 1; (Q == 0) when UP = 0.
  - MODE 01/10: at_end = (Q == TERM), for either direction.
- Free-run (00/11):
  - Q <= Q+1 when UP = 1, Q <= Q-1 when UP = 0, modulo 2^W.
  - Wrap-around is natural (all ones -> 0 up, 0 -> all ones down).
- Modulo (01):
  - If at_end, Q <= D (reload).
  - Otherwise Q <= Q±1 as in free-run.
  - If Q passes TERM without matching it (TERM changed mid-count), wrap at 2^W as in free-run.
- One-shot (10):
  - If DONE = 1, hold Q.
  - Else if at_end, hold Q and set DONE <= 1.
  - Else Q <= Q±1.
  - DONE stays 1 until CLL or LD, or until MODE leaves 10; leaving 10 clears DONE on the next edge.
- CO = CI & at_end & ~(MODE == 10 & DONE). It is purely combinational and has no register delay.
  - This preserves ripple cascading: the upper stage's CI is tied to the lower stage's CO.
- CO is not gated by CLL or LD. A cascaded upper stage sharing CLL/LD is cleared or loaded by the same priority rule.
- QB always equals ~Q; it is derived, not a separately stored state.
- UP and MODE are sampled every edge, so a change takes effect on the very next count.
- Latency:
  - Q changes one edge after the enabling condition.
  - DONE rises on the edge that detects Q == TERM with CI = 1, i.e. one CI-cycle after Q reaches TERM.

Decomposition:
- Shared package `syndcnt_pkg` holds:
  - typedef `cnt_mode_t` (enum, 2 bits): MODE_FREE = 0, MODE_MOD = 1, MODE_ONESHOT = 2, MODE_RSVD = 3.
  - constant MAX_W = 32.
- One sub-module is natural: `syndcnt_next`.
  - Purely combinational next-state logic.
  - Inputs: Q, D, TERM, UP, MODE, DONE, CI, LD, CLL.
  - Outputs: next Q, next DONE, at_end.
- The top level holds only the asynchronously reset registers, the QB and CO assigns, and a parameter-range assertion.

Test Plan (all with W = 4, RESET_VAL = 0):
- Reset mid-count: free-run up, CI = 1, Q = 5; pulse RESL low between edges -> Q = 0, QB = 15 immediately (no clock edge), DONE = 0; counting resumes 1, 2, … after release.
- Free-run wrap, both directions:
  - UP = 1, CI = 1 from Q = 14 -> Q = 15 with CO = 1, then Q = 0 with CO = 0.
  - UP = 0 from Q = 1 -> Q = 0 with CO = 1, then Q = 15.
- Modulo: MODE = 01, TERM = 9, D = 3, UP = 1, start Q = 7 -> sequence 8, 9, 3, 4; CO = 1 only while Q = 9.
- One-shot: MODE = 10, TERM = 2, UP = 0, LD with D = 5, then CI = 1 -> sequence 4, 3, 2, 2; DONE = 1 from the fourth edge; CO pulses only at the first Q = 2 cycle; LD with D = 5 clears DONE and restarts.
- Priority: CLL = 0, LD = 1, CI = 1, D = 7 at the same edge -> Q = 0; then CLL = 1, LD = 1, CI = 1 -> Q = 7, no increment.
- Cascade: two W = 4 instances, upper CI = lower CO, free-run up from 0x0F -> one edge gives lower = 0 and upper = 1; from 0xFF -> 0x00 with the upper CO = 1 in the preceding cycle.
